// File: rtl/mux_scan_seq.sv
// mux_scan_seq: scan sequencer for the A3 analog mux bank.
// Walks a latched channel mask through select, settle, convert and store, and yields the mux to the host.
module mux_scan_seq #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cont,
    input  logic [12:0] ch_mask,
    input  logic        host_req,
    output logic        host_gnt,
    output logic [4:0]  a3_code,
    output logic        a3_en,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [15:0] adc_data,
    output logic        res_we,
    output logic [3:0]  res_addr,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        done_p,
    output logic        tmo_err
);

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE, CONV, STORE, NEXT, HOST
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [4:0]  cur, cur_nxt;
    logic [12:0] mask_q;
    logic        cont_q;
    logic [15:0] cnt;
    logic [15:0] cap, cap_nxt;
    logic        from_idle, from_idle_nxt;
    logic        cfg_ld, tmo_set, done_set;
    logic [12:0] hi_mask;
    logic        has_nxt;
    logic [4:0]  nxt_ch;

    function automatic logic [4:0] low_bit(input logic [12:0] m);
        low_bit = 5'd0;
        for (int i = 12; i >= 0; i--)
            if (m[i]) low_bit = 5'(i);
    endfunction

    // Channels strictly above cur; empty when cur is the top code.
    assign hi_mask = mask_q & ~((13'd2 << cur) - 13'd1);
    assign has_nxt = (|hi_mask) | cont_q;
    assign nxt_ch  = (|hi_mask) ? low_bit(hi_mask) : low_bit(mask_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            cnt       <= '0;
            cap       <= '0;
            from_idle <= 1'b0;
            tmo_err   <= 1'b0;
            done_p    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            cap       <= cap_nxt;
            from_idle <= from_idle_nxt;
            done_p    <= done_set;
            cnt       <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            if (cfg_ld) begin
                mask_q <= ch_mask;
                cont_q <= cont;
            end
            if (cfg_ld)       tmo_err <= 1'b0;
            else if (tmo_set) tmo_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        cap_nxt       = cap;
        from_idle_nxt = from_idle;
        cfg_ld        = 1'b0;
        tmo_set       = 1'b0;
        done_set      = 1'b0;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    state_nxt     = HOST;
                    from_idle_nxt = 1'b1;
                end else if (start) begin
                    if (|ch_mask) begin
                        cfg_ld    = 1'b1;
                        cur_nxt   = low_bit(ch_mask);
                        state_nxt = SELECT;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            SELECT: state_nxt = SETTLE;
            SETTLE: if (cnt == SETTLE_LAST) state_nxt = CONV;
            CONV: begin
                if (adc_done) begin
                    cap_nxt   = adc_data;
                    state_nxt = STORE;
                end else if (cnt == TMO_LAST) begin
                    cap_nxt   = 16'hFFFF;
                    tmo_set   = 1'b1;
                    state_nxt = STORE;
                end
            end
            STORE: state_nxt = NEXT;
            NEXT: begin
                if (stop) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end else if (host_req) begin
                    from_idle_nxt = 1'b0;
                    state_nxt     = HOST;
                end else if (has_nxt) begin
                    cur_nxt   = nxt_ch;
                    state_nxt = SELECT;
                end else begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOST: begin
                if (!host_req) begin
                    if (from_idle) begin
                        state_nxt = IDLE;
                    end else if (has_nxt) begin
                        cur_nxt   = nxt_ch;
                        state_nxt = SELECT;
                    end else begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        host_gnt  = 1'b0;
        a3_en     = 1'b0;
        a3_code   = '0;
        adc_start = 1'b0;
        res_we    = 1'b0;
        res_addr  = '0;
        res_data  = '0;
        busy      = 1'b1;
        unique case (state)
            IDLE:   busy = 1'b0;
            SELECT: a3_code = cur;
            SETTLE: begin
                a3_en   = 1'b1;
                a3_code = cur;
            end
            CONV: begin
                a3_en     = 1'b1;
                a3_code   = cur;
                adc_start = (cnt == 16'd0);
            end
            STORE: begin
                a3_code  = cur;
                res_we   = 1'b1;
                res_addr = cur[3:0];
                res_data = cap;
            end
            NEXT:   a3_code = cur;
            HOST: begin
                busy     = 1'b0;
                host_gnt = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Automatic measurement-scan sequencer for the A3 analog multiplexer bank (D19/D20/D21 groups, channel codes 0–12). Once armed by the host, it steps through a latched channel mask. For each channel it selects the mux address, then enables it after one cycle, waits a settling interval, and handshakes one ADC conversion. It stores each result into an external result RAM. It also arbitrates the mux between the automatic scan and manual host access, so the host select-register path and the scan never drive the mux simultaneously.

## Interface
- SETTLE_CYC, 16: cycles of enabled mux before ADC start (1–255).
- TIMEOUT_CYC, 1024: max cycles waiting for adc_done (≥2).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. The block has one clock, and reset is asynchronous and active-high.
- start  in  1  one-cycle pulse that arms a scan; honoured only in IDLE.
- stop  in  1  level; ends the scan at the next channel boundary.
- cont  in  1  continuous mode, sampled with start.
- ch_mask  in  13  enabled channel codes (bit n = code n), sampled with start.
- host_req  in  1  host requests exclusive mux ownership.
- host_gnt  out  1  mux released to host.
- a3_code  out  5  mux channel code to the mux decode logic.
- a3_en  out  1  mux enable.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  one-cycle conversion complete, qualifies adc_data.
- adc_data  in  16  conversion result.
- res_we  out  1  result write strobe.
- res_addr  out  4  result address (= channel code).
- res_data  out  16  result word.
- busy  out  1  high in every state except IDLE and HOST.
- done_p  out  1  one-cycle end-of-scan pulse.
- tmo_err  out  1  sticky timeout flag, cleared by start.

## Operation
- States: IDLE, SELECT, SETTLE, CONV, STORE, NEXT, HOST.
- IDLE:
  - host_req has priority → HOST.
  - Otherwise, start with ch_mask≠0 → latch mask/cont, clear tmo_err, cur = lowest set bit, go to SELECT.
  - start with ch_mask=0 → done_p pulses, stay in IDLE.
- SELECT (1 cycle): a3_code=cur, a3_en=0 → SETTLE.
- SETTLE: a3_en=1, counter runs 0..SETTLE_CYC-1 → CONV.
- CONV:
  - adc_start pulses on the entry cycle only. a3_en stays 1.
  - Wait for adc_done. On adc_done, capture adc_data → STORE.
  - If TIMEOUT_CYC cycles pass without adc_done, capture 16'hFFFF, set tmo_err → STORE.
- STORE (1 cycle): res_we=1, res_addr=cur[3:0], res_data=captured value → NEXT.
- NEXT (1 cycle), a3_en=0. Priority order:
  1. stop → done_p, IDLE.
  2. host_req → HOST, with the resume point remembered.
  3. A higher set bit exists → cur = that bit, SELECT.
  4. No higher bit and cont=1 → wrap to the lowest set bit, SELECT.
  5. Otherwise → done_p, IDLE.
- HOST:
  - host_gnt=1, a3_en=0, a3_code=0. busy=0.
  - When host_req drops, return to the remembered point: SELECT with the next channel (same wrap rule), or IDLE if entered from IDLE.
  - A resumed scan that has no next channel and cont=0 → done_p, IDLE.
- a3_en is 1 only in SETTLE and CONV.
- host_gnt is 1 only in HOST.
- A host_req arriving mid-channel is not honoured until NEXT. The current conversion always completes.
- stop and start in IDLE on the same cycle: start wins, and stop is checked at the first NEXT.
- adc_done outside CONV is ignored.

## Timing
- Reset value of every output is 0, and tmo_err=0. Reset asserted mid-scan returns the block to IDLE with the mux disabled immediately (asynchronous).
- Channel latency from SELECT entry to the res_we cycle is 1 + SETTLE_CYC + 1 + D + 1 cycles, where D is the number of cycles from the adc_start cycle to the adc_done cycle (D≥1).
- start at cycle 0 → SELECT at cycle 1 → a3_en high at cycle 2.
- done_p is asserted the cycle after the final NEXT.
- host_gnt rises one cycle after a NEXT that sees host_req, or one cycle after IDLE sees host_req. It falls one cycle after host_req drops.
- The timeout counter counts from the adc_start cycle. If adc_done arrives exactly on cycle TIMEOUT_CYC-1, the real data is used.

## Test plan
- SETTLE_CYC=4, mask=13'h0007, cont=0, adc_done 3 cycles after each start:
  - Expected writes: addr 0,1,2 with the supplied data.
  - Each channel takes 10 cycles.
  - a3_en low ≥1 cycle between channels.
  - One done_p.
- mask=13'h1001, cont=1, assert stop during channel 12's CONV:
  - Channel 12 is stored, then done_p follows.
  - The wrap 12→0 is observed before stop.
- host_req raised during SETTLE of channel 5 (mask 13'h0060):
  - Channel 5 completes.
  - host_gnt=1 and a3_en=0 until release.
  - The scan resumes on channel 6, then done_p.
- adc_done withheld for channel 3:
  - After TIMEOUT_CYC cycles, addr 3 is written with 16'hFFFF and tmo_err=1.
  - The next start clears tmo_err.
- start with ch_mask=0 → done_p only, no a3_en.
- start together with host_req in IDLE → HOST, no scan.
- rst asserted mid-CONV → all outputs are 0 in the same cycle, and the block restarts cleanly on the next start.
